// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor, CHUNK bits of carry chain per register stage.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int STAGES = WIDTH / CHUNK;

   // Bit offset of stage k's operand skew slice (WIDTH - CHUNK*(k+1) bits each).
   function automatic int skw_off(input int k);
      return k * WIDTH - (CHUNK * k * (k + 1)) / 2;
   endfunction

   // Bit offset of stage k's deskewed partial sum slice (CHUNK*(k+1) bits each).
   function automatic int sum_off(input int k);
      return (CHUNK * k * (k + 1)) / 2;
   endfunction

   localparam int SKW_BITS = (STAGES > 1) ? skw_off(STAGES - 1) : 1;
   localparam int SUM_BITS = sum_off(STAGES);

   // Handshake: an operation enters when in_valid && in_ready, a result leaves when
   // out_valid && out_ready; every slot shifts together whenever the output slot is
   // empty or being consumed, so in_ready is exactly that advance condition.
   logic                adv;
   logic [WIDTH-1:0]    bx;
   logic [STAGES-1:0]   vld;
   logic [STAGES-1:0]   cry;
   logic [SKW_BITS-1:0] a_skw;
   logic [SKW_BITS-1:0] b_skw;
   logic [SUM_BITS-1:0] dsk;

`ifdef PIPELINED_ADDER_OVF_EN
   logic [CHUNK:0] top_s;
   logic           top_a;
   logic           top_b;
`endif

   assign adv       = !vld[STAGES-1] || out_ready;
   assign in_ready  = adv;
   assign bx        = sub ? ~b : b;
   assign out_valid = vld[STAGES-1];
   assign cout      = cry[STAGES-1];
   assign sum       = dsk[sum_off(STAGES-1) +: WIDTH];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int REM = WIDTH - CHUNK * k;
      localparam int LOW = CHUNK * k;

      logic [REM-1:0]       a_in;
      logic [REM-1:0]       b_in;
      logic                 c_in;
      logic                 v_in;
      logic [CHUNK:0]       s;
      logic [LOW+CHUNK-1:0] p_d;
      logic                 v_q;
      logic                 c_q;
      logic [LOW+CHUNK-1:0] p_q;

      if (k == 0) begin : g_src
         assign a_in = a;
         assign b_in = bx;
         assign c_in = sub | cin;
         assign v_in = in_valid;
         assign p_d  = s[CHUNK-1:0];
      end else begin : g_src
         assign a_in = a_skw[skw_off(k-1) +: REM];
         assign b_in = b_skw[skw_off(k-1) +: REM];
         assign c_in = cry[k-1];
         assign v_in = vld[k-1];
         assign p_d  = {s[CHUNK-1:0], dsk[sum_off(k-1) +: LOW]};
      end

      assign s = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            p_q <= '0;
         end else if (adv) begin
            v_q <= v_in;
            c_q <= s[CHUNK];
            p_q <= p_d;
         end
      end

      assign vld[k] = v_q;
      assign cry[k] = c_q;
      assign dsk[sum_off(k) +: LOW+CHUNK] = p_q;

      // Operand chunks not yet added ride along one stage behind their carry.
      if (k < STAGES - 1) begin : g_skw
         logic [REM-CHUNK-1:0] a_q;
         logic [REM-CHUNK-1:0] b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_in[REM-1:CHUNK];
               b_q <= b_in[REM-1:CHUNK];
            end
         end

         assign a_skw[skw_off(k) +: REM-CHUNK] = a_q;
         assign b_skw[skw_off(k) +: REM-CHUNK] = b_q;
      end

`ifdef PIPELINED_ADDER_OVF_EN
      if (k == STAGES - 1) begin : g_top
         assign top_s = s;
         assign top_a = a_in[CHUNK-1];
         assign top_b = b_in[CHUNK-1];
      end
`endif
   end

`ifdef PIPELINED_ADDER_OVF_EN
   // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (adv) begin
         ovf <= (top_s[CHUNK-1] ^ top_a ^ top_b) ^ top_s[CHUNK];
      end
   end
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, CHUNK=4): vector table, streaming,
// backpressure and mid-flight reset sequences.
module tb_pipelined_adder;

   localparam int W      = 16;
   localparam int C      = 4;
   localparam int STAGES = W / C;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         in_ready;
   logic [W-1:0] a         = '0;
   logic [W-1:0] b         = '0;
   logic         cin       = 1'b0;
   logic         sub       = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;
`ifdef PIPELINED_ADDER_OVF_EN
   logic         ovf;
`endif

   int           n_cmp = 0;
   int           n_bad = 0;
   int           cyc   = 0;
   logic         sb_en = 1'b0;
   logic [W:0]   exp_q[$];
   int           out_cyc[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } vec_t;

   vec_t tbl[12];

   pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .cin(cin),
      .sub(sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum(sum),
      .cout(cout)
`ifdef PIPELINED_ADDER_OVF_EN
      ,
      .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
      logic [W:0] r;
      if (s) r = {(x >= y), W'(x - y)};
      else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      return r;
   endfunction

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                       input logic tci, input logic tsu);
      int n;
      n        = 0;
      a        = ta;
      b        = tbv;
      cin      = tci;
      sub      = tsu;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
   endtask

   // Scoreboard: push the reference result on each input transfer, pop on each output transfer.
   always @(negedge clk) begin
      if (sb_en && rst_n) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", {15'd0, cout, sum}, 32'hFFFF_FFFF);
            end else begin
               chk("sb_result", {15'd0, cout, sum}, {15'd0, exp_q.pop_front()});
            end
            out_cyc.push_back(cyc);
         end
         if (in_valid && in_ready) exp_q.push_back(ref_op(a, b, cin, sub));
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int n;

      tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[1]  = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[2]  = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
      tbl[3]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      tbl[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      tbl[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      tbl[7]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      tbl[8]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
      tbl[9]  = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      tbl[10] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[11] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;

      // Vector table: one operation at a time, latency and result checked
      for (int i = 0; i < 12; i++) begin
         send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
         n = 1;
         while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk($sformatf("tbl%0d_latency", i), n, STAGES);
         chk($sformatf("tbl%0d_sum", i), {16'd0, sum}, {16'd0, tbl[i].s});
         chk($sformatf("tbl%0d_cout", i), {31'd0, cout}, {31'd0, tbl[i].c});
`ifdef PIPELINED_ADDER_OVF_EN
         chk($sformatf("tbl%0d_ovf", i), {31'd0, ovf}, {31'd0, tbl[i].v});
`endif
      end
      repeat (2) @(posedge clk);
      #1;

      // Back-to-back: 8 operations on consecutive cycles
      sb_en = 1'b1;
      out_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         send(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain(30);
      chk("b2b_drained", exp_q.size(), 32'd0);
      chk("b2b_count", out_cyc.size(), 32'd8);
      if (out_cyc.size() == 8) chk("b2b_spacing", out_cyc[7] - out_cyc[0], 32'd7);

      // Backpressure: 3-cycle stall in the middle of a stream
      out_cyc.delete();
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               send(W'(i * 16'h1357), W'(16'hFFFF - i * 16'h0101), 1'(i), 1'(i >> 1));
            end
         end
         begin
            int m;
            m = 0;
            @(negedge clk);
            while (!out_valid && m < 30) begin
               @(negedge clk);
               m++;
            end
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               chk($sformatf("bp%0d_in_ready", j), {31'd0, in_ready}, 32'd0);
               chk($sformatf("bp%0d_out_valid", j), {31'd0, out_valid}, 32'd1);
               chk($sformatf("bp%0d_hold", j), {15'd0, cout, sum}, {15'd0, exp_q[0]});
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain(40);
      chk("bp_drained", exp_q.size(), 32'd0);
      chk("bp_count", out_cyc.size(), 32'd10);

      // Reset with three operations in flight and the first one stalled at the output
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(W'(16'h0100 + i), 16'h0011, 1'b0, 1'b0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("rf_pre_valid", {31'd0, out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rf_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rf_sum", {16'd0, sum}, 32'd0);
      chk("rf_cout", {31'd0, cout}, 32'd0);
      exp_q.delete();
      out_cyc.delete();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      chk("rf_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (12) @(negedge clk);
      chk("rf_no_ghost", out_cyc.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
